ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Owns the PC register and issues word fetches to instruction memory over a valid/ready request channel with variable-latency response.
- Registers each returned instruction and presents it with its PC to decode over a valid/ready handshake.
- Accepts PC redirects from downstream (branch/jump) and squashes wrong-path fetches.

Parameters:
DATA_WIDTH, 32, PC/address width
RESET_PC, 32'h8000_0000, PC loaded on reset

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  DATA_WIDTH  fetch address (word aligned)
imem_rsp_valid  input  1  response valid, one per accepted request
imem_rsp_data  input  32  fetched instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst  output  32  registered instruction
inst_pc  output  DATA_WIDTH  PC of inst
redirect_valid  input  1  downstream requests PC change
redirect_pc  input  DATA_WIDTH  new PC; bits [1:0] ignored (forced 0)
fetch_cnt  output  32  count of completed inst handshakes, wraps

Behaviour:
- Reset (rst=1 at posedge): pc<=RESET_PC, state<=REQ, kill<=0, fetch_cnt<=0, inst<=0, inst_pc<=0. imem_req_valid=0 and inst_valid=0 while rst is high. Reset mid-fetch abandons any outstanding request; a response arriving after reset is ignored while state!=WAIT.
- States: REQ, WAIT, HOLD.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On req_valid&req_ready: go WAIT.
  - Redirect with no accept: pc<=redirect_pc, stay REQ; the new address is driven next cycle.
  - Redirect with accept: pc<=redirect_pc, kill<=1, go WAIT.
- WAIT:
  - imem_req_valid=0. At most one request is outstanding.
  - Memory guarantees rsp_valid no earlier than the cycle after accept.
  - On rsp_valid with kill=0 and no redirect: inst<=rsp_data, inst_pc<=pc, go HOLD.
  - On rsp_valid with kill=1 or redirect_valid: discard data, kill<=0, go REQ.
  - Redirect without rsp: kill<=1, pc<=redirect_pc.
  - Repeated redirects: the last one wins.
- HOLD:
  - inst_valid=1. inst and inst_pc stay stable until the handshake completes.
  - On inst_valid&inst_ready: fetch_cnt<=fetch_cnt+1, pc<=pc+4 (wraps mod 2^DATA_WIDTH), go REQ.
  - Redirect: pc<=redirect_pc (overrides pc+4), go REQ.
    - Handshake in the same cycle still counts as consumed.
    - Without inst_ready, the held instruction is dropped and not counted.
- Best-case throughput: 3 cycles per instruction (REQ accept → rsp next cycle → HOLD handshake). First imem_req_valid appears in the first cycle after rst deasserts.
- Redirect priority: redirect > sequential pc+4 in every state.
- fetch_cnt wraps 32'hFFFF_FFFF → 0.

Test Plan:
- Reset then zero-wait memory returning addr-tagged data, inst_ready=1 → imem_req_addr sequence 0x80000000, 0x80000004, 0x80000008; inst_pc matches; inst=mem data; fetch_cnt=3 after 9 cycles.
- imem_req_ready low 4 cycles, then rsp delayed 3 cycles → req_valid held with stable addr; exactly one inst delivered; no duplicate request.
- inst_ready low 5 cycles in HOLD → inst/inst_pc stable, no new request, fetch_cnt unchanged; ready high → count+1, next addr pc+4.
- Redirect to 0x80001003 during WAIT → pending rsp discarded (inst_valid stays 0); next request addr 0x80001000.
- Redirect in HOLD with inst_ready=1 to 0x80000100 → fetch_cnt+1, next addr 0x80000100 (not pc+4); same with inst_ready=0 → fetch_cnt unchanged.
- Assert rst while in WAIT, memory responds next cycle → response ignored, outputs at reset values, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage feeding decode.
// Owns the PC, issues one word fetch at a time to instruction memory,
// registers the returned word and hands it to decode with its PC.
// Downstream redirects replace the PC and squash any wrong-path fetch.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_REQ  | driving a fetch request at pc, waiting for memory accept
// S_WAIT | one request outstanding, waiting for the response
// S_HOLD | instruction registered, presented to decode until taken
module ifu_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [31:0]           fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic                  kill;
    logic [DATA_WIDTH-1:0] redirect_pc_al;
    logic                  req_fire;
    logic                  inst_fire;

    // Redirect targets are word aligned; low two bits are simply cleared.
    assign redirect_pc_al = redirect_pc & ~DATA_WIDTH'(3);

    // Handshake outputs decode the registered state; both are held low during reset.
    assign imem_req_valid = (state == S_REQ) && !rst;
    assign inst_valid     = (state == S_HOLD) && !rst;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_fire      = inst_valid && inst_ready;

    // Fetch FSM: PC, squash flag, instruction register and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            fetch_cnt <= 32'd0;
            inst      <= 32'd0;
            inst_pc   <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc_al;
                    end
                    if (req_fire) begin
                        // The accepted request used the old pc; its data must be dropped.
                        kill  <= redirect_valid;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill || redirect_valid) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst    <= imem_rsp_data;
                            inst_pc <= pc;
                            state   <= S_HOLD;
                        end
                        if (redirect_valid) begin
                            pc <= redirect_pc_al;
                        end
                    end else if (redirect_valid) begin
                        kill <= 1'b1;
                        pc   <= redirect_pc_al;
                    end
                end
                S_HOLD: begin
                    // A handshake coinciding with a redirect still counts as consumed.
                    if (inst_fire) begin
                        fetch_cnt <= fetch_cnt + 32'd1;
                    end
                    if (redirect_valid) begin
                        pc    <= redirect_pc_al;
                        state <= S_REQ;
                    end else if (inst_fire) begin
                        pc    <= pc + DATA_WIDTH'(4);
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch with a variable-latency memory model.
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_cnt;

    always #5 clk = ~clk;

    ifu_fetch #(.DATA_WIDTH(32), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_cnt      (fetch_cnt)
    );

    int          n_tot = 0;
    int          n_bad = 0;
    logic [31:0] exp_req_q[$];
    logic [63:0] exp_inst_q[$];
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          mem_lat;
    int          n_acc = 0;
    int          n;

    function automatic logic [31:0] tagf(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] addr, input bit deliver);
        exp_req_q.push_back(addr);
        if (deliver) exp_inst_q.push_back({addr, tagf(addr)});
    endtask

    // One clock: observe handshakes at negedge, then drive the memory response after posedge.
    task automatic tick();
        logic [31:0] e;
        logic [63:0] ei;
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            n_acc++;
            chk("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
            if (exp_req_q.size() != 0) begin
                e = exp_req_q.pop_front();
                chk("req_addr", imem_req_addr, e);
            end
        end
        if (inst_valid && inst_ready) begin
            chk("inst_expected", 32'(exp_inst_q.size() != 0), 32'd1);
            if (exp_inst_q.size() != 0) begin
                ei = exp_inst_q.pop_front();
                chk("inst_pc", inst_pc, ei[63:32]);
                chk("inst", inst, ei[31:0]);
            end
        end
        if (imem_rsp_valid) pend = 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            pend_cnt  = mem_lat;
        end
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = tagf(pend_addr);
            end
        end
    endtask

    task automatic run_until(input int budget, output int cycles);
        cycles = 0;
        while ((exp_req_q.size() != 0 || exp_inst_q.size() != 0) && cycles < budget) begin
            tick();
            cycles++;
        end
        chk("run_drained", 32'(exp_req_q.size() + exp_inst_q.size()), 32'd0);
        exp_req_q.delete();
        exp_inst_q.delete();
        imem_req_ready = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int c = 0;
        while (!inst_valid && c < budget) begin
            tick();
            c++;
        end
        chk("wait_inst_valid", 32'(inst_valid), 32'd1);
    endtask

    task automatic wait_acc(input int budget);
        int c = 0;
        int start = n_acc;
        while (n_acc == start && c < budget) begin
            tick();
            c++;
        end
        chk("wait_accept", 32'(n_acc != start), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        mem_lat        = 1;
        pend           = 1'b0;
        pend_addr      = 32'd0;
        pend_cnt       = 0;

        // Reset, then zero-wait memory with decode always ready.
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        push_fetch(RPC, 1);
        push_fetch(RPC + 32'd4, 1);
        push_fetch(RPC + 32'd8, 1);
        rst = 1'b0;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        run_until(30, n);
        chk("s1_cycles", n, 32'd9);
        chk("s1_cnt", fetch_cnt, 32'd3);

        // Memory stalls the request for 4 cycles, then answers 3 cycles after accept.
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", 32'(imem_req_valid), 32'd1);
            chk("stall_addr", imem_req_addr, RPC + 32'd12);
            tick();
        end
        push_fetch(RPC + 32'd12, 1);
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        run_until(30, n);
        chk("s2_cycles", n, 32'd5);
        chk("s2_cnt", fetch_cnt, 32'd4);

        // Decode back-pressure for 5 cycles while holding an instruction.
        inst_ready     = 1'b0;
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        push_fetch(RPC + 32'd16, 1);
        wait_valid(20);
        for (int i = 0; i < 5; i++) begin
            chk("hold_inst", inst, tagf(RPC + 32'd16));
            chk("hold_pc", inst_pc, RPC + 32'd16);
            chk("hold_no_req", 32'(imem_req_valid), 32'd0);
            chk("hold_cnt", fetch_cnt, 32'd4);
            tick();
        end
        push_fetch(RPC + 32'd20, 1);
        inst_ready = 1'b1;
        run_until(30, n);
        chk("s3_cnt", fetch_cnt, 32'd6);

        // Redirect to an unaligned target while a response is outstanding.
        imem_req_ready = 1'b1;
        mem_lat        = 3;
        push_fetch(RPC + 32'd24, 0);
        wait_acc(20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1003;
        push_fetch(32'h8000_1000, 1);
        tick();
        redirect_valid = 1'b0;
        chk("wait_redir_no_inst", 32'(inst_valid), 32'd0);
        run_until(30, n);
        chk("s4_cnt", fetch_cnt, 32'd7);

        // Redirect in HOLD together with a handshake: consumed and counted.
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        mem_lat        = 1;
        push_fetch(32'h8000_1004, 1);
        wait_valid(20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        inst_ready     = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("s5a_cnt", fetch_cnt, 32'd8);
        push_fetch(32'h8000_0100, 1);
        run_until(30, n);
        chk("s5a_cnt_after", fetch_cnt, 32'd9);

        // Redirect in HOLD without a handshake: the held instruction is dropped.
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        push_fetch(32'h8000_0104, 0);
        wait_valid(20);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        redirect_valid = 1'b0;
        chk("s5b_cnt", fetch_cnt, 32'd9);
        push_fetch(32'h8000_0200, 1);
        inst_ready = 1'b1;
        run_until(30, n);
        chk("s5b_cnt_after", fetch_cnt, 32'd10);

        // Reset while waiting; the stale response lands the cycle after reset.
        imem_req_ready = 1'b1;
        mem_lat        = 2;
        push_fetch(32'h8000_0204, 0);
        wait_acc(20);
        rst = 1'b1;
        #1;
        chk("s6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("s6_rst_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        rst = 1'b0;
        push_fetch(RPC, 1);
        #1;
        chk("s6_stale_rsp_present", 32'(imem_rsp_valid), 32'd1);
        chk("s6_cnt", fetch_cnt, 32'd0);
        chk("s6_inst", inst, 32'd0);
        chk("s6_inst_pc", inst_pc, 32'd0);
        chk("s6_req_addr", imem_req_addr, RPC);
        run_until(30, n);
        chk("s6_cnt_after", fetch_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
